// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences PC, memory, register file and ALU muxes.
// Optional overflow exception path enabled by defining MULTICYCLE_CTRL_EXC_EN.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       overflow,
   input  logic       mem_ready,
   output logic       alu_src_a,
   output logic [2:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       pc_write,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       epc_write,
   output logic [3:0] state
);

   localparam int unsigned StateW = 4;

   localparam logic [5:0] OpRType = 6'h00;
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpJ     = 6'h02;

   typedef enum logic [StateW-1:0] {
      StReset   = 4'd0,
      StFetch   = 4'd1,
      StDecode  = 4'd2,
      StMemAddr = 4'd3,
      StMemRd   = 4'd4,
      StLwWb    = 4'd5,
      StMemWr   = 4'd6,
      StExecR   = 4'd7,
      StRWb     = 4'd8,
      StExecI   = 4'd9,
      StIWb     = 4'd10,
      StBranch  = 4'd11,
      StJump    = 4'd12,
      StExc     = 4'd13
   } state_t;

   state_t curState, nextState;

`ifndef MULTICYCLE_CTRL_EXC_EN
   logic unusedOverflow;
   assign unusedOverflow = overflow;
`endif

   // State register; reset forces RESET so all strobes drop immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) curState <= StReset;
      else          curState <= nextState;
   end

   assign state = curState;

   // Next-state and control decode.
   always_comb begin
      nextState  = StReset;
      alu_src_a  = 1'b0;
      alu_src_b  = 3'b100;
      alu_op     = 2'b00;
      pc_source  = 2'b00;
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      epc_write  = 1'b0;

      case (curState)
         StReset: nextState = StFetch;
         StFetch: begin
            mem_read  = 1'b1;
            alu_src_b = 3'b001;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            nextState = mem_ready ? StDecode : StFetch;
         end
         StDecode: begin
            alu_src_b = 3'b011;
            case (opcode)
               OpRType:   nextState = StExecR;
               OpAddi:    nextState = StExecI;
               OpLw, OpSw: nextState = StMemAddr;
               OpBeq:     nextState = StBranch;
               OpJ:       nextState = StJump;
               default:   nextState = StFetch;
            endcase
         end
         StMemAddr: begin
            alu_src_a = 1'b1;
            alu_src_b = 3'b010;
            nextState = (opcode == OpSw) ? StMemWr : StMemRd;
         end
         StMemRd: begin
            iord      = 1'b1;
            mem_read  = 1'b1;
            nextState = mem_ready ? StLwWb : StMemRd;
         end
         StLwWb: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            nextState  = StFetch;
         end
         StMemWr: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            nextState = mem_ready ? StFetch : StMemWr;
         end
         StExecR: begin
            alu_src_a = 1'b1;
            alu_src_b = 3'b000;
            alu_op    = 2'b10;
`ifdef MULTICYCLE_CTRL_EXC_EN
            nextState = overflow ? StExc : StRWb;
`else
            nextState = StRWb;
`endif
         end
         StRWb: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            nextState = StFetch;
         end
         StExecI: begin
            alu_src_a = 1'b1;
            alu_src_b = 3'b010;
`ifdef MULTICYCLE_CTRL_EXC_EN
            nextState = overflow ? StExc : StIWb;
`else
            nextState = StIWb;
`endif
         end
         StIWb: begin
            reg_write = 1'b1;
            nextState = StFetch;
         end
         StBranch: begin
            alu_src_a = 1'b1;
            alu_src_b = 3'b000;
            alu_op    = 2'b01;
            pc_source = 2'b01;
            pc_write  = zero;
            nextState = StFetch;
         end
         StJump: begin
            pc_source = 2'b10;
            pc_write  = 1'b1;
            nextState = StFetch;
         end
`ifdef MULTICYCLE_CTRL_EXC_EN
         // PC-4 recovers the faulting instruction address into EPC.
         StExc: begin
            alu_src_b = 3'b001;
            alu_op    = 2'b01;
            epc_write = 1'b1;
            pc_source = 2'b11;
            pc_write  = 1'b1;
            nextState = StFetch;
         end
`endif
         default: nextState = StReset;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model predicts the
// per-cycle state and control word; a negedge monitor compares against the DUT.
module tb_multicycle_ctrl;

   localparam int S_RESET = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADDR = 3, S_MEMRD = 4,
                  S_LWWB = 5, S_MEMWR = 6, S_EXECR = 7, S_RWB = 8, S_EXECI = 9,
                  S_IWB = 10, S_BRANCH = 11, S_JUMP = 12, S_EXC = 13;

`ifdef MULTICYCLE_CTRL_EXC_EN
   localparam bit ExcEn = 1'b1;
`else
   localparam bit ExcEn = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] st;
      logic       srcA;
      logic [2:0] srcB;
      logic [1:0] aluOp;
      logic [1:0] pcSrc;
      logic       pcW;
      logic       iord;
      logic       memRd;
      logic       memWr;
      logic       irW;
      logic       regDst;
      logic       m2r;
      logic       regW;
      logic       epcW;
   } ctl_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] opcode;
   logic       zero, overflow, mem_ready;
   logic       alu_src_a;
   logic [2:0] alu_src_b;
   logic [1:0] alu_op, pc_source;
   logic       pc_write, iord, mem_read, mem_write, ir_write;
   logic       reg_dst, mem_to_reg, reg_write, epc_write;
   logic [3:0] state;

   int nCmp = 0;
   int nErr = 0;
   ctl_t sbQ[$];

   multicycle_ctrl dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .overflow(overflow),
      .mem_ready(mem_ready), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .epc_write(epc_write), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic ctl_t actCtl();
      ctl_t c;
      c = '{state, alu_src_a, alu_src_b, alu_op, pc_source, pc_write, iord, mem_read,
            mem_write, ir_write, reg_dst, mem_to_reg, reg_write, epc_write};
      return c;
   endfunction

   // Control word each state must present, given the inputs it may depend on.
   function automatic ctl_t expCtl(input int st, input logic mr, input logic z);
      ctl_t c;
      c = '0;
      c.st = 4'(st);
      c.srcB = 3'b100;
      case (st)
         S_FETCH:   begin c.memRd = 1'b1; c.srcB = 3'b001; c.irW = mr; c.pcW = mr; end
         S_DECODE:  c.srcB = 3'b011;
         S_MEMADDR: begin c.srcA = 1'b1; c.srcB = 3'b010; end
         S_MEMRD:   begin c.iord = 1'b1; c.memRd = 1'b1; end
         S_LWWB:    begin c.m2r = 1'b1; c.regW = 1'b1; end
         S_MEMWR:   begin c.iord = 1'b1; c.memWr = 1'b1; end
         S_EXECR:   begin c.srcA = 1'b1; c.srcB = 3'b000; c.aluOp = 2'b10; end
         S_RWB:     begin c.regDst = 1'b1; c.regW = 1'b1; end
         S_EXECI:   begin c.srcA = 1'b1; c.srcB = 3'b010; end
         S_IWB:     c.regW = 1'b1;
         S_BRANCH:  begin c.srcA = 1'b1; c.srcB = 3'b000; c.aluOp = 2'b01; c.pcSrc = 2'b01; c.pcW = z; end
         S_JUMP:    begin c.pcSrc = 2'b10; c.pcW = 1'b1; end
         S_EXC:     begin c.srcB = 3'b001; c.aluOp = 2'b01; c.epcW = 1'b1; c.pcSrc = 2'b11; c.pcW = 1'b1; end
         default:   ;
      endcase
      return c;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock of stimulus: drive inputs, predict this cycle's control word, advance.
   task automatic step(input int st, input logic mr, input logic z, input logic ovf);
      mem_ready = mr;
      zero      = z;
      overflow  = ovf;
      sbQ.push_back(expCtl(st, mr, z));
      @(posedge clk);
      #1;
   endtask

   // Reference model of one instruction from FETCH back to FETCH.
   task automatic runInstr(input logic [5:0] op, input int fw, input int mw,
                           input logic z, input logic ovf);
      opcode = op;
      repeat (fw) step(S_FETCH, 1'b0, rb(), rb());
      step(S_FETCH, 1'b1, rb(), rb());
      step(S_DECODE, rb(), rb(), rb());
      case (op)
         6'h00: begin
            step(S_EXECR, rb(), rb(), ovf);
            if (ExcEn && ovf) step(S_EXC, rb(), rb(), rb());
            else              step(S_RWB, rb(), rb(), rb());
         end
         6'h08: begin
            step(S_EXECI, rb(), rb(), ovf);
            if (ExcEn && ovf) step(S_EXC, rb(), rb(), rb());
            else              step(S_IWB, rb(), rb(), rb());
         end
         6'h23: begin
            step(S_MEMADDR, rb(), rb(), rb());
            repeat (mw) step(S_MEMRD, 1'b0, rb(), rb());
            step(S_MEMRD, 1'b1, rb(), rb());
            step(S_LWWB, rb(), rb(), rb());
         end
         6'h2B: begin
            step(S_MEMADDR, rb(), rb(), rb());
            repeat (mw) step(S_MEMWR, 1'b0, rb(), rb());
            step(S_MEMWR, 1'b1, rb(), rb());
         end
         6'h04: step(S_BRANCH, rb(), z, rb());
         6'h02: step(S_JUMP, rb(), rb(), rb());
         default: ;
      endcase
   endtask

   // Monitor: every cycle the DUT presents a control word, compare against the model.
   always @(negedge clk) begin
      if (sbQ.size() != 0) begin
         ctl_t e;
         e = sbQ.pop_front();
         chk($sformatf("ctl_st%0d", e.st), 32'(actCtl()), 32'(e));
      end
   end

   // Checks of the asynchronously forced reset control word.
   task automatic chkResetOutputs(input string tag);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_srcb"}, 32'(alu_src_b), 32'd4);
      chk({tag, "_memwr"}, 32'(mem_write), 32'd0);
      chk({tag, "_ctl"}, 32'(actCtl()), 32'(expCtl(S_RESET, 1'b0, 1'b0)));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      opcode = 6'h00; zero = 1'b0; overflow = 1'b0; mem_ready = 1'b0;
      #3;
      chkResetOutputs("rst_async");
      repeat (2) @(posedge clk);
      #1;
      chkResetOutputs("rst_hold");
      reset_n = 1'b1;
      step(S_RESET, 1'b1, 1'b0, 1'b0);

      runInstr(6'h00, 0, 0, 1'b0, 1'b0);
      runInstr(6'h23, 0, 3, 1'b0, 1'b0);
      runInstr(6'h04, 0, 0, 1'b1, 1'b0);
      runInstr(6'h04, 0, 0, 1'b0, 1'b0);
      runInstr(6'h08, 0, 0, 1'b0, 1'b1);
      runInstr(6'h00, 1, 0, 1'b0, 1'b1);
      runInstr(6'h3F, 0, 0, 1'b0, 1'b0);
      runInstr(6'h02, 2, 0, 1'b0, 1'b0);
      runInstr(6'h2B, 0, 2, 1'b0, 1'b0);

      // Reset asserted while a store is stalled in MEM_WR.
      opcode = 6'h2B;
      step(S_FETCH, 1'b1, 1'b0, 1'b0);
      step(S_DECODE, 1'b1, 1'b0, 1'b0);
      step(S_MEMADDR, 1'b1, 1'b0, 1'b0);
      mem_ready = 1'b0;
      sbQ.push_back(expCtl(S_MEMWR, 1'b0, zero));
      @(negedge clk);
      #2;
      chk("memwr_before_rst", 32'(mem_write), 32'd1);
      reset_n = 1'b0;
      #1;
      chkResetOutputs("rst_midwr");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(S_RESET, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 300; i++) begin
         logic [5:0] op;
         case ($urandom_range(0, 6))
            0: op = 6'h00;
            1: op = 6'h08;
            2: op = 6'h23;
            3: op = 6'h2B;
            4: op = 6'h04;
            5: op = 6'h02;
            default: op = 6'($urandom);
         endcase
         runInstr(op, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                  $urandom_range(0, 3), rb(), rb());
      end

      @(negedge clk);
      #1;
      chk("sb_drain", 32'(sbQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
